monty_premul: RTL
=================

# monty_premul

Operand front-end for the word-level Montgomery datapath. It accepts operand pairs (A, B) with a per-sample modulus tag qH under a valid/ready handshake. It computes the exact double-width product C = A·B in a tiled DSP pipeline and presents C and qH, cycle-aligned, to the free-running reduction stage (`wlm_mixed`). Because the reduction pipeline cannot stall, this block enforces back-pressure with a credit counter sized to the result FIFO that sits after the reduction.

## Interface
Parameters:
- `LOGQ`, 32, operand width in bits.
- `LOGQH`, 15, modulus tag width; must match the reduction stage.
- `FF_IN`, 1, 1 = register the operands and tag on acceptance.
- `FF_MUL`, 1, 1 = register the partial products.
- `FF_OUT`, 1, 1 = register C, qH and out_valid.
- `CREDITS`, 16, depth of the downstream result FIFO; must be ≥1.

Ports:
- `clk` in 1: sole clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair and tag present.
- `in_ready` out 1: block can accept this cycle.
- `A`, `B` in LOGQ: unsigned operands.
- `qH_in` in LOGQH: modulus tag travelling with the pair.
- `credit_ret` in 1: one-cycle pulse; one result was popped from the downstream FIFO.
- `out_valid` out 1: C and qH_out valid this cycle.
- `C` out 2·LOGQ: product, connected directly to the reduction stage C input.
- `qH_out` out LOGQH: tag aligned with C, connected to the reduction stage qH input.
- `err_credit` out 1: sticky flag; set by a credit return while the counter is already full.

## Operation
- Accept = `in_valid & in_ready`. A non-accepted cycle injects a bubble: out_valid is 0 for that slot, and C and qH_out are don't-care.
- Operand split:
  - H = (LOGQ+1)/2.
  - AL = A[H-1:0], AH = A[LOGQ-1:H]; BL and BH are split the same way.
- Partial products: PLL = AL·BL, PLH = AL·BH, PHL = AH·BL, PHH = AH·BH.
- Sum: C = (PHH << 2H) + ((PLH+PHL) << H) + PLL.
  - Middle sum is held at 2H+1 bits.
  - Final result is exactly 2·LOGQ bits; no truncation, no overflow.
- qH and the valid bit travel in shift registers matched to the data latency.
- Credit counter `cnt`, width clog2(CREDITS+1):
  - Reset value is CREDITS.
  - Accept only: cnt−1.
  - credit_ret only: cnt+1.
  - Both in the same cycle: unchanged.
- `in_ready` = (cnt ≠ 0). It is decoded from the register only, so there is no combinational path from in_valid.
- credit_ret while cnt = CREDITS (and no accept that cycle): cnt holds at CREDITS and err_credit sets. err_credit clears only on reset.
- The block has no state machine beyond the counter. The datapath never stalls: it is a pure pipeline with bubbles.

## Timing
- Latency, accept edge to out_valid = FF_IN + FF_MUL + 1 + FF_OUT. The summation stage is always registered, so the default latency is 4.
- Throughput is one pair per cycle while cnt > 0.
- in_ready updates the cycle after the accept that drives cnt to 0.
- Reset, asynchronous and immediate:
  - out_valid = 0, C = 0, qH_out = 0, err_credit = 0, cnt = CREDITS.
  - All pipeline valid bits clear, so in-flight items are discarded.
  - The downstream FIFO must be reset together with this block.
- Release of rst_n is synchronous to clk. in_ready = 1 from the first cycle after release.

## Structure
- Shared header (alongside the existing reduction parameter header):
  - `monty_premul_params_t` = {LOGQ, LOGQH, FF_IN, FF_MUL, FF_OUT}.
  - Functions `monty_premul_lat()` and `monty_premul_split()` (returns H).
  - Top-level wrappers use these to size FIFOs and align side-band data.
- One sub-module, `credit_counter`:
  - Parameter: CREDITS.
  - Ports: clk, rst_n, take, give, avail, err.
  - Reused by other stream fronts.
- Multiplier tiles use the existing DSP macros; no separate module.

## Test plan
- A = B = 0xFFFFFFFF, qH_in = 0x3001 → 4 cycles later: out_valid = 1 for exactly 1 cycle, C = 0xFFFFFFFE00000001, qH_out = 0x3001.
- A = B = 0x00010001 → C = 0x0000000100020001. Repeat with FF_IN = 0 → same C, latency 3.
- 16 back-to-back accepts with no credit_ret → in_ready = 0 in the cycle after the 16th accept; a held 17th in_valid is not accepted; a single credit_ret → exactly one further accept.
- At cnt = 1: accept and credit_ret in the same cycle → cnt stays 1, in_ready stays 1.
- credit_ret at cnt = 16 → err_credit = 1 and stays 1; cnt stays 16.
- rst_n low with 3 items in flight → out_valid = 0 immediately, no outputs after release, in_ready = 1 and cnt = 16.
- 10k random pairs with random in_valid and credit_ret → C matches the reference model, qH_out is aligned, no loss or duplication, cnt never exceeds CREDITS.

Source files
------------

// File: rtl/monty_premul_pkg.sv
// Shared parameter record and sizing helpers for the Montgomery operand front-end.
package monty_premul_pkg;

  typedef struct packed {
    int unsigned logq;
    int unsigned logqh;
    int unsigned ff_in;
    int unsigned ff_mul;
    int unsigned ff_out;
  } monty_premul_params_t;

  // Low-half width of the operand split; the high half gets the remainder.
  function automatic int unsigned monty_premul_split(monty_premul_params_t p);
    return (p.logq + 32'd1) / 32'd2;
  endfunction

  // Accept-to-out_valid latency; the summation register is always present.
  function automatic int unsigned monty_premul_lat(monty_premul_params_t p);
    return 32'(p.ff_in != 0) + 32'(p.ff_mul != 0) + 32'd1 + 32'(p.ff_out != 0);
  endfunction

endpackage

// File: rtl/monty_premul_credit_counter.sv
// Credit counter for a non-stalling stream: take consumes, give returns, sticky error on overflow.
module credit_counter #(
  parameter int unsigned CREDITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic take,
  input  logic give,
  output logic avail,
  output logic err
);

  localparam int unsigned CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          err_nxt;

  // Simultaneous take and give cancel; give at full is dropped and flagged.
  always_comb begin
    cnt_nxt = cnt;
    err_nxt = err;
    if (take && !give && (cnt != '0)) begin
      cnt_nxt = cnt - CW'(1);
    end else if (give && !take) begin
      if (cnt == FULL) begin
        err_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // avail is registered from the next count so it has no path from take/give.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= FULL;
      avail <= 1'b1;
      err   <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      avail <= (cnt_nxt != '0);
      err   <= err_nxt;
    end
  end

endmodule

// File: rtl/monty_premul.sv
// Operand front-end: tiled exact A*B product with aligned tag, credit-gated input, bubble pipeline.
module monty_premul
  import monty_premul_pkg::*;
#(
  parameter int unsigned LOGQ    = 32,
  parameter int unsigned LOGQH   = 15,
  parameter int unsigned FF_IN   = 1,
  parameter int unsigned FF_MUL  = 1,
  parameter int unsigned FF_OUT  = 1,
  parameter int unsigned CREDITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LOGQ-1:0]     A,
  input  logic [LOGQ-1:0]     B,
  input  logic [LOGQH-1:0]    qH_in,
  input  logic                credit_ret,
  output logic                out_valid,
  output logic [2*LOGQ-1:0]   C,
  output logic [LOGQH-1:0]    qH_out,
  output logic                err_credit
);

  localparam monty_premul_params_t P = '{logq: LOGQ, logqh: LOGQH, ff_in: FF_IN,
                                         ff_mul: FF_MUL, ff_out: FF_OUT};
  localparam int unsigned H  = monty_premul_split(P);
  localparam int unsigned LW = H;
  localparam int unsigned HW = LOGQ - H;
  localparam int unsigned PW = 2 * LOGQ;
  localparam int unsigned MW = 2 * H + 1;

  logic accept;
  assign accept = in_valid & in_ready;

  credit_counter #(.CREDITS(CREDITS)) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .take  (accept),
    .give  (credit_ret),
    .avail (in_ready),
    .err   (err_credit)
  );

  // Stage 0: optional operand capture.
  logic             s0_v;
  logic [LOGQ-1:0]  s0_a;
  logic [LOGQ-1:0]  s0_b;
  logic [LOGQH-1:0] s0_q;

  if (FF_IN != 0) begin : g_in_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s0_v <= 1'b0;
        s0_a <= '0;
        s0_b <= '0;
        s0_q <= '0;
      end else begin
        s0_v <= accept;
        s0_a <= A;
        s0_b <= B;
        s0_q <= qH_in;
      end
    end
  end else begin : g_in_byp
    assign s0_v = accept;
    assign s0_a = A;
    assign s0_b = B;
    assign s0_q = qH_in;
  end

  // Stage 1: four partial-product tiles.
  logic [LW-1:0]      al, bl;
  logic [HW-1:0]      ah, bh;
  logic [2*LW-1:0]    pll_c;
  logic [LW+HW-1:0]   plh_c, phl_c;
  logic [2*HW-1:0]    phh_c;

  assign al    = s0_a[LW-1:0];
  assign ah    = s0_a[LOGQ-1:LW];
  assign bl    = s0_b[LW-1:0];
  assign bh    = s0_b[LOGQ-1:LW];
  assign pll_c = (2*LW)'(al) * (2*LW)'(bl);
  assign plh_c = (LW+HW)'(al) * (LW+HW)'(bh);
  assign phl_c = (LW+HW)'(ah) * (LW+HW)'(bl);
  assign phh_c = (2*HW)'(ah) * (2*HW)'(bh);

  logic             s1_v;
  logic [LOGQH-1:0] s1_q;
  logic [2*LW-1:0]  s1_ll;
  logic [LW+HW-1:0] s1_lh, s1_hl;
  logic [2*HW-1:0]  s1_hh;

  if (FF_MUL != 0) begin : g_mul_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_v  <= 1'b0;
        s1_q  <= '0;
        s1_ll <= '0;
        s1_lh <= '0;
        s1_hl <= '0;
        s1_hh <= '0;
      end else begin
        s1_v  <= s0_v;
        s1_q  <= s0_q;
        s1_ll <= pll_c;
        s1_lh <= plh_c;
        s1_hl <= phl_c;
        s1_hh <= phh_c;
      end
    end
  end else begin : g_mul_byp
    assign s1_v  = s0_v;
    assign s1_q  = s0_q;
    assign s1_ll = pll_c;
    assign s1_lh = plh_c;
    assign s1_hl = phl_c;
    assign s1_hh = phh_c;
  end

  // Stage 2: always-registered recombination; the middle sum keeps its carry bit.
  logic [MW-1:0]    mid_c;
  logic [PW-1:0]    sum_c;
  logic             s2_v;
  logic [LOGQH-1:0] s2_q;
  logic [PW-1:0]    s2_c;

  assign mid_c = MW'(s1_lh) + MW'(s1_hl);
  assign sum_c = (PW'(s1_hh) << (2*H)) + (PW'(mid_c) << H) + PW'(s1_ll);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v <= 1'b0;
      s2_q <= '0;
      s2_c <= '0;
    end else begin
      s2_v <= s1_v;
      s2_q <= s1_q;
      s2_c <= sum_c;
    end
  end

  // Stage 3: optional output register toward the reduction stage.
  if (FF_OUT != 0) begin : g_out_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid <= 1'b0;
        qH_out    <= '0;
        C         <= '0;
      end else begin
        out_valid <= s2_v;
        qH_out    <= s2_q;
        C         <= s2_c;
      end
    end
  end else begin : g_out_byp
    assign out_valid = s2_v;
    assign qH_out    = s2_q;
    assign C         = s2_c;
  end

endmodule
